fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch sequencer at the start of the fetch cycle. It owns the program counter, issues one read at a time to instruction memory over a valid/ready request channel, and captures the returned word. It presents the word with its PC to decode over a valid/ready channel, then advances PC by 4. Taken branches and jumps redirect fetch and squash any in-flight fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned read address
- imem_resp_valid  in  1  read data valid, one pulse per accepted request
- imem_resp_data  in  32  instruction word
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst_data  out  32  instruction word
- inst_pc  out  32  PC of inst_data
- redirect_valid  in  1  load new PC, squash current fetch
- redirect_pc  in  32  target PC; bits [1:0] forced to 0

## Operation
- One clock, clk. Reset is asynchronous and active-high on rst.
- States: IDLE, REQ, WAIT, HOLD, DRAIN. At most one outstanding request.
- Reset values:
  - state=IDLE, pc=RESET_PC
  - inst_valid=0, inst_data=0, inst_pc=0
  - imem_req_valid=0
- IDLE: always goes to REQ on the next clock.
- REQ:
  - imem_req_valid=1 and imem_req_addr=pc, both from state (no combinational input path).
  - On imem_req_ready, go to WAIT.
- WAIT:
  - On imem_resp_valid, load inst_data=imem_resp_data and inst_pc=pc, set inst_valid=1.
  - Same edge: pc <= pc+4 (mod 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000). Go to HOLD.
- HOLD:
  - inst_valid=1; outputs stay stable while inst_ready=0.
  - On inst_ready, clear inst_valid and go to REQ.
- DRAIN: wait for imem_resp_valid of the squashed request, discard the data, go to REQ.
- imem_resp_valid is ignored in IDLE, REQ and HOLD.
- Redirect has priority over every other event in the cycle. It always sets pc <= {redirect_pc[31:2],2'b00} and clears inst_valid. The next state depends on the current state:
  - IDLE: stay IDLE, then go to REQ as normal.
  - REQ without imem_req_ready: stay in REQ. Address changes next cycle; a withdrawn request is legal for the memory.
  - REQ with imem_req_ready: the request was accepted, so go to DRAIN.
  - WAIT without imem_resp_valid: go to DRAIN.
  - WAIT with imem_resp_valid: discard the response, go to REQ.
  - HOLD: go to REQ. If inst_ready is also high, the transfer counts as completed.
  - DRAIN without imem_resp_valid: stay in DRAIN.
  - DRAIN with imem_resp_valid: go to REQ.
- Reset mid-operation: all state returns to reset values immediately. Any outstanding memory response after rst deasserts is a memory-side protocol violation and is not tracked.

## Timing
- Request accepted at edge N (req_valid & req_ready). Response is legal from cycle N+1 onward.
- Response at edge M gives inst_valid=1 from cycle M+1. pc is incremented at edge M.
- With zero-wait memory and decode, one instruction every 3 cycles (REQ, WAIT, HOLD).
- First imem_req_valid appears 1 cycle after rst deasserts (IDLE, then REQ).
- After a redirect at edge R:
  - imem_req_addr=new pc no earlier than cycle R+1.
  - If a squash was needed, it is delayed until the drained response arrives.
- inst_data and inst_pc change only on entry to HOLD.

## Test plan
- **Reset and sequential fetch.** RESET_PC=0x100, zero-wait memory returning addr^0xA5A5_0000, inst_ready=1.
  - Requests go to 0x100, 0x104, 0x108.
  - inst_pc/inst_data pairs are (0x100, 0xA5A5_0100), and so on.
  - One instruction every 3 cycles.
- **Backpressure.** Hold inst_ready=0 for 5 cycles in HOLD.
  - inst_valid, inst_data and inst_pc stay stable.
  - No new request is issued.
  - Fetch resumes one cycle after inst_ready=1.
- **Redirect in WAIT.** Memory latency 4, redirect_pc=0x203 asserted 1 cycle after the request is accepted.
  - The stale response is dropped; no inst_valid for it.
  - The next request goes to 0x200.
  - The first delivered inst_pc is 0x200.
- **Simultaneous events.**
  - Redirect and imem_resp_valid in the same WAIT cycle: go directly to REQ at the new pc, with no DRAIN cycle.
  - Redirect and imem_req_ready in the same REQ cycle: enter DRAIN.
- **Wrap-around.** RESET_PC=0xFFFF_FFFC.
  - The second request address is 0x0000_0000.
- **Asynchronous reset mid-HOLD.** Assert rst between edges.
  - inst_valid and imem_req_valid drop immediately, without waiting for clk.
  - After release, the first request goes to RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, issues one instruction-memory read
// at a time, and hands each returned word with its PC to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned SW = 3;

  localparam logic [SW-1:0] IDLE  = 3'd0;
  localparam logic [SW-1:0] REQ   = 3'd1;
  localparam logic [SW-1:0] WAIT  = 3'd2;
  localparam logic [SW-1:0] HOLD  = 3'd3;
  localparam logic [SW-1:0] DRAIN = 3'd4;

  logic [SW-1:0] state, state_n;
  logic [31:0]   pc, pc_n;
  logic [31:0]   inst_data_n, inst_pc_n;
  logic          inst_valid_n;
  logic          req_valid_n;
  logic [31:0]   redirect_target;
  logic          redirect_lsb_unused;

  // Redirect targets are word aligned; the low two bits are dropped.
  assign redirect_target     = {redirect_pc[31:2], 2'b00};
  assign redirect_lsb_unused = |redirect_pc[1:0];

  // The request address is the PC register itself, so it has no input path.
  assign imem_req_addr = pc;

  // Next-state, next-PC and next-output logic; redirect overrides all events.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    inst_valid_n = inst_valid;
    inst_data_n  = inst_data;
    inst_pc_n    = inst_pc;

    case (state)
      IDLE:  state_n = REQ;
      REQ:   if (imem_req_ready) state_n = WAIT;
      WAIT: begin
        if (imem_resp_valid) begin
          inst_data_n  = imem_resp_data;
          inst_pc_n    = pc;
          inst_valid_n = 1'b1;
          pc_n         = pc + 32'd4;
          state_n      = HOLD;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          inst_valid_n = 1'b0;
          state_n      = REQ;
        end
      end
      DRAIN: if (imem_resp_valid) state_n = REQ;
      default: state_n = IDLE;
    endcase

    if (redirect_valid) begin
      pc_n         = redirect_target;
      inst_valid_n = 1'b0;
      inst_data_n  = inst_data;
      inst_pc_n    = inst_pc;
      case (state)
        IDLE:    state_n = IDLE;
        REQ:     state_n = imem_req_ready  ? DRAIN : REQ;
        WAIT:    state_n = imem_resp_valid ? REQ   : DRAIN;
        HOLD:    state_n = REQ;
        DRAIN:   state_n = imem_resp_valid ? REQ   : DRAIN;
        default: state_n = IDLE;
      endcase
    end

    req_valid_n = (state_n == REQ);
  end

  // State, PC and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      imem_req_valid <= 1'b0;
      inst_valid     <= 1'b0;
      inst_data      <= 32'h0;
      inst_pc        <= 32'h0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      imem_req_valid <= req_valid_n;
      inst_valid     <= inst_valid_n;
      inst_data      <= inst_data_n;
      inst_pc        <= inst_pc_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// corner sequences, then randomized traffic against a transaction-level model.
module tb_fetch_unit;

  localparam logic [31:0] TAG = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_ready, resp_valid, inst_ready, redirect_valid;
  logic [31:0] resp_data, redirect_pc;
  logic        req_valid, inst_valid;
  logic [31:0] req_addr, inst_data, inst_pc;

  logic        w_req_valid, w_inst_valid_unused;
  logic [31:0] w_req_addr, w_inst_pc, w_inst_data_unused;

  fetch_unit #(.RESET_PC(32'h0000_0100)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // Free-running instance used only to observe PC wrap-around.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
    .imem_resp_valid(1'b1), .imem_resp_data(32'h1234_5678),
    .inst_valid(w_inst_valid_unused), .inst_ready(1'b1),
    .inst_data(w_inst_data_unused), .inst_pc(w_inst_pc),
    .redirect_valid(1'b0), .redirect_pc(32'h0)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rr;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        red;
    logic [31:0] rpc;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_idata;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rr, input logic rv, input logic [31:0] rd,
                       input logic ir, input logic red, input logic [31:0] rpc);
    req_ready      = rr;
    resp_valid     = rv;
    resp_data      = rd;
    inst_ready     = ir;
    redirect_valid = red;
    redirect_pc    = rpc;
  endtask

  task automatic check_out(input string tag, input logic e_rv, input logic [31:0] e_addr,
                           input logic e_iv, input logic [31:0] e_ipc, input logic [31:0] e_idata);
    check({tag, ".req_valid"}, 32'(req_valid), 32'(e_rv));
    check({tag, ".req_addr"}, req_addr, e_addr);
    check({tag, ".inst_valid"}, 32'(inst_valid), 32'(e_iv));
    check({tag, ".inst_pc"}, inst_pc, e_ipc);
    check({tag, ".inst_data"}, inst_data, e_idata);
  endtask

  // Random-phase model state
  logic [31:0] exp_pc, paddr, acc_addr, h_pc, h_data;
  logic        pend, acc, hold, red_seen;
  int          pwait, n_deliv, since;

  initial begin
    // Sequential fetch and backpressure, starting right after reset release.
    vt[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0,   32'h0};
    vt[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b0, 32'h100, 1'b0, 32'h0,   32'h0};
    vt[2]  = '{1'b0, 1'b1, 32'hA5A5_0100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h104, 1'b1, 32'h100, 32'hA5A5_0100};
    vt[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 32'h100, 32'hA5A5_0100};
    vt[4]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0, 32'h100, 32'hA5A5_0100};
    vt[5]  = '{1'b0, 1'b1, 32'hA5A5_0104, 1'b0, 1'b0, 32'h0, 1'b0, 32'h108, 1'b1, 32'h104, 32'hA5A5_0104};
    vt[6]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b0, 32'h108, 1'b1, 32'h104, 32'hA5A5_0104};
    vt[7]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 32'h108, 1'b1, 32'h104, 32'hA5A5_0104};
    vt[8]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b0, 32'h108, 1'b1, 32'h104, 32'hA5A5_0104};
    vt[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b0, 32'h108, 1'b1, 32'h104, 32'hA5A5_0104};
    vt[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b0, 32'h108, 1'b1, 32'h104, 32'hA5A5_0104};
    vt[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b1, 32'h108, 1'b0, 32'h104, 32'hA5A5_0104};
    vt[12] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b0, 32'h108, 1'b0, 32'h104, 32'hA5A5_0104};
    vt[13] = '{1'b0, 1'b1, 32'hA5A5_0108, 1'b1, 1'b0, 32'h0, 1'b0, 32'h10C, 1'b1, 32'h108, 32'hA5A5_0108};
    vt[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b1, 32'h10C, 1'b0, 32'h108, 32'hA5A5_0108};

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].rr, vt[i].rv, vt[i].rd, vt[i].ir, vt[i].red, vt[i].rpc);
      cyc();
      check_out($sformatf("vec%0d", i), vt[i].e_rv, vt[i].e_addr, vt[i].e_iv, vt[i].e_ipc, vt[i].e_idata);
      if (i == 0) check("wrap.first_addr", w_req_addr, 32'hFFFF_FFFC);
      if (i == 2) check("wrap.inst_pc", w_inst_pc, 32'hFFFF_FFFC);
      if (i == 3) begin
        check("wrap.second_valid", 32'(w_req_valid), 32'd1);
        check("wrap.second_addr", w_req_addr, 32'h0000_0000);
      end
    end

    // Redirect one cycle after acceptance, memory latency 4.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc();
    check("rw.accept", 32'(req_valid), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h203);
    cyc();
    check_out("rw.drain", 1'b0, 32'h200, 1'b0, 32'h108, 32'hA5A5_0108);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc();
    check_out("rw.drain2", 1'b0, 32'h200, 1'b0, 32'h108, 32'hA5A5_0108);
    cyc();
    check_out("rw.drain3", 1'b0, 32'h200, 1'b0, 32'h108, 32'hA5A5_0108);
    drive(1'b0, 1'b1, 32'hA5A5_010C, 1'b0, 1'b0, 32'h0);
    cyc();
    check_out("rw.stale_dropped", 1'b1, 32'h200, 1'b0, 32'h108, 32'hA5A5_0108);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc();
    drive(1'b0, 1'b1, 32'hA5A5_0200, 1'b0, 1'b0, 32'h0);
    cyc();
    check_out("rw.first_new", 1'b0, 32'h204, 1'b1, 32'h200, 32'hA5A5_0200);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc();
    check_out("rw.resume", 1'b1, 32'h204, 1'b0, 32'h200, 32'hA5A5_0200);

    // Redirect together with request acceptance: must drain.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
    cyc();
    check_out("sim_req.drain", 1'b0, 32'h300, 1'b0, 32'h200, 32'hA5A5_0200);
    drive(1'b0, 1'b1, 32'hA5A5_0204, 1'b0, 1'b0, 32'h0);
    cyc();
    check_out("sim_req.after", 1'b1, 32'h300, 1'b0, 32'h200, 32'hA5A5_0200);

    // Redirect together with a response: straight back to REQ.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc();
    drive(1'b0, 1'b1, 32'hA5A5_0300, 1'b0, 1'b1, 32'h400);
    cyc();
    check_out("sim_wait.req", 1'b1, 32'h400, 1'b0, 32'h200, 32'hA5A5_0200);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc();
    drive(1'b0, 1'b1, 32'hA5A5_0400, 1'b0, 1'b0, 32'h0);
    cyc();
    check_out("sim_wait.deliver", 1'b0, 32'h404, 1'b1, 32'h400, 32'hA5A5_0400);

    // Redirect in HOLD without decode accept, then redirect in REQ without ready.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h501);
    cyc();
    check_out("hold_redirect", 1'b1, 32'h500, 1'b0, 32'h400, 32'hA5A5_0400);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h600);
    cyc();
    check_out("req_withdraw", 1'b1, 32'h600, 1'b0, 32'h400, 32'hA5A5_0400);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc();
    drive(1'b0, 1'b1, 32'hA5A5_0600, 1'b0, 1'b0, 32'h0);
    cyc();
    check_out("pre_reset_hold", 1'b0, 32'h604, 1'b1, 32'h600, 32'hA5A5_0600);

    // Asynchronous reset between edges while holding an instruction.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check_out("async_reset", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0);
    cyc();
    rst = 1'b0;
    cyc();
    check_out("after_reset", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);

    // Randomized traffic against a transaction-level model.
    exp_pc  = 32'h100;
    pend    = 1'b0;
    paddr   = 32'h0;
    pwait   = 0;
    n_deliv = 0;
    since   = 0;
    for (int c = 0; c < 3000; c++) begin
      req_ready      = ($urandom_range(0, 2) != 0);
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom();
      resp_valid     = 1'b0;
      resp_data      = $urandom();
      if (pend) begin
        pwait--;
        if (pwait == 0) begin
          resp_valid = 1'b1;
          resp_data  = paddr ^ TAG;
        end
      end

      acc      = req_valid && req_ready;
      acc_addr = req_addr;
      if (acc) begin
        check("rnd.one_outstanding", 32'(pend), 32'd0);
        check("rnd.addr_align", 32'(req_addr[1:0]), 32'd0);
      end
      if (inst_valid && inst_ready) begin
        check("rnd.inst_pc", inst_pc, exp_pc);
        check("rnd.inst_data", inst_data, exp_pc ^ TAG);
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
        since = 0;
      end
      hold     = inst_valid && !inst_ready && !redirect_valid;
      h_pc     = inst_pc;
      h_data   = inst_data;
      red_seen = redirect_valid;
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};

      cyc();

      if (resp_valid) pend = 1'b0;
      if (acc) begin
        pend  = 1'b1;
        pwait = $urandom_range(1, 4);
        paddr = acc_addr;
      end
      if (hold) begin
        check("rnd.hold_valid", 32'(inst_valid), 32'd1);
        check("rnd.hold_pc", inst_pc, h_pc);
        check("rnd.hold_data", inst_data, h_data);
      end
      if (red_seen) check("rnd.redirect_clears", 32'(inst_valid), 32'd0);
      since++;
      if (since > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL rnd.watchdog: got no delivery for %0d cycles, required at most 200", since);
        break;
      end
    end
    check("rnd.min_deliveries", 32'(n_deliv >= 100), 32'd1);

    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
